// File: rtl/guess_game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : guess_pkg
// Description : Shared types and constants for the guess-number game
//               sequencer: FSM state encoding, key codes, field widths and
//               a small key-decode helper.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package guess_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SCORE_W    = 3;   // holds 0..4
  localparam int CNT_W      = 3;   // entry count 0..4
  localparam int ATT_W      = 4;   // attempts, saturating at 15

  localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hA;
  localparam logic [DIGIT_W-1:0] KEY_ENTER = 4'hB;

  localparam logic [ATT_W-1:0]   ATT_MAX   = 4'd15;

  typedef enum logic [1:0] {
    Q_ENTRY = 2'd0,
    A_ENTRY = 2'd1,
    COMPARE = 2'd2,
    RESULT  = 2'd3
  } state_t;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  // Codes 0..9 are digits; everything above is a command or ignored.
  function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
    return (code <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/guess_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : guess_game_ctrl_if
// Description : Keypad input and display-driver output bundle of the game
//               sequencer.
// Ports       : key_valid/key_code  keypad strobe and code (into the sequencer)
//               qa_state, digit_state, match, show, r_a, r_b, attempts
//                                   display / status outputs
//               modport slave  : sequencer side
//               modport master : keypad / display side
// Revision    : 1.0  initial release
// ============================================================================
interface guess_game_ctrl_if;
  import guess_pkg::*;

  logic                 key_valid;
  logic [DIGIT_W-1:0]   key_code;
  logic                 qa_state;
  logic [1:0]           digit_state;
  logic                 match;
  logic                 show;
  logic [SCORE_W-1:0]   r_a;
  logic [SCORE_W-1:0]   r_b;
  logic [ATT_W-1:0]     attempts;

  modport slave (
    input  key_valid, key_code,
    output qa_state, digit_state, match, show, r_a, r_b, attempts
  );

  modport master (
    output key_valid, key_code,
    input  qa_state, digit_state, match, show, r_a, r_b, attempts
  );

endinterface
`default_nettype wire

// File: rtl/guess_game_ctrl_ab_score.sv
`default_nettype none
// ============================================================================
// Module      : ab_score
// Description : Combinational A/B scorer. A counts positions where question
//               and guess digits agree; B counts digits shared between the
//               two (multiset intersection) that are not already counted as A.
// Ports       : q_i  question digits (4 x 4 bit)
//               g_i  guess digits    (4 x 4 bit)
//               a_o  right digit, right place (0..4)
//               b_o  right digit, wrong place (0..4)
// Revision    : 1.0  initial release
// ============================================================================
module ab_score
  import guess_pkg::*;
(
  input  digits_t              q_i,
  input  digits_t              g_i,
  output logic [SCORE_W-1:0]   a_o,
  output logic [SCORE_W-1:0]   b_o
);

  function automatic logic [SCORE_W-1:0] count_of(input digits_t v,
                                                  input logic [DIGIT_W-1:0] d);
    logic [SCORE_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      n = n + SCORE_W'(v[i] == d);
    end
    return n;
  endfunction

  logic [SCORE_W-1:0] min_cnt [10];
  logic [SCORE_W-1:0] a_sum;
  logic [SCORE_W-1:0] common;

  // Shared digits per value: duplicates only count as often as they appear
  // in both words.
  genvar d;
  generate
    for (d = 0; d < 10; d++) begin : g_digit
      logic [SCORE_W-1:0] cq;
      logic [SCORE_W-1:0] cg;
      assign cq         = count_of(q_i, DIGIT_W'(d));
      assign cg         = count_of(g_i, DIGIT_W'(d));
      assign min_cnt[d] = (cq < cg) ? cq : cg;
    end
  endgenerate

  always_comb begin
    a_sum  = '0;
    common = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      a_sum = a_sum + SCORE_W'(q_i[i] == g_i[i]);
    end
    // Sum never exceeds 4, so the 3-bit accumulator cannot wrap.
    for (int k = 0; k < 10; k++) begin
      common = common + min_cnt[k];
    end
  end

  // Every exact hit is also a shared digit, so common >= a_sum.
  assign a_o = a_sum;
  assign b_o = common - a_sum;

endmodule
`default_nettype wire

// File: rtl/guess_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : guess_game_ctrl
// Description : Guess-number game sequencer. Collects a 4-digit question,
//               then 4-digit guesses, scores each guess (A/B) and drives the
//               dot-matrix display driver, blinking the score for a fixed
//               number of toggles before returning to entry.
// Ports       : clk_div  scan clock shared with the display driver
//               reset    asynchronous, active-low
//               bus      guess_game_ctrl_if.slave
//                        key_valid/key_code in; qa_state, digit_state,
//                        match, show, r_a, r_b, attempts out
// Revision    : 1.0  initial release
// ============================================================================
module guess_game_ctrl
  import guess_pkg::*;
#(
  parameter int BLINK_CYCLES  = 500,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic                   clk_div,
  input  logic                   reset,
  guess_game_ctrl_if.slave       bus
);

  localparam int BLINK_W = (BLINK_CYCLES  > 1) ? $clog2(BLINK_CYCLES)  : 1;
  localparam int TOG_W   = (BLINK_TOGGLES > 1) ? $clog2(BLINK_TOGGLES) : 1;

  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [TOG_W-1:0]   TOG_LAST   = TOG_W'(BLINK_TOGGLES - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(NUM_DIGITS);

  state_t               state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  digits_t              q_q,      q_d;
  digits_t              g_q,      g_d;
  logic [SCORE_W-1:0]   ra_q,     ra_d;
  logic [SCORE_W-1:0]   rb_q,     rb_d;
  logic [ATT_W-1:0]     att_q,    att_d;
  logic                 match_q,  match_d;
  logic                 show_q,   show_d;
  logic [BLINK_W-1:0]   blink_q,  blink_d;
  logic [TOG_W-1:0]     tog_q,    tog_d;

  logic [SCORE_W-1:0]   score_a;
  logic [SCORE_W-1:0]   score_b;

  ab_score u_ab_score (
    .q_i (q_q),
    .g_i (g_q),
    .a_o (score_a),
    .b_o (score_b)
  );

  always_ff @(posedge clk_div or negedge reset) begin
    if (!reset) begin
      state_q <= Q_ENTRY;
      cnt_q   <= '0;
      q_q     <= '0;
      g_q     <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      att_q   <= '0;
      match_q <= 1'b0;
      show_q  <= 1'b0;
      blink_q <= '0;
      tog_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      g_q     <= g_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      att_q   <= att_d;
      match_q <= match_d;
      show_q  <= show_d;
      blink_q <= blink_d;
      tog_q   <= tog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    g_d     = g_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    att_d   = att_q;
    match_d = match_q;
    show_d  = show_q;
    blink_d = blink_q;
    tog_d   = tog_q;

    unique case (state_q)
      Q_ENTRY, A_ENTRY: begin
        if (bus.key_valid) begin
          if (is_digit(bus.key_code)) begin
            // A fifth digit is dropped; the operator must clear or enter.
            if (cnt_q < CNT_FULL) begin
              if (state_q == Q_ENTRY) q_d[cnt_q[1:0]] = bus.key_code;
              else                    g_d[cnt_q[1:0]] = bus.key_code;
              cnt_d = cnt_q + 3'd1;
            end
          end else if (bus.key_code == KEY_CLEAR) begin
            // Digit registers keep stale values; they are overwritten on
            // re-entry before they can be scored.
            cnt_d = '0;
          end else if (bus.key_code == KEY_ENTER && cnt_q == CNT_FULL) begin
            if (state_q == Q_ENTRY) begin
              state_d = A_ENTRY;
              cnt_d   = '0;
              att_d   = '0;
            end else begin
              state_d = COMPARE;
            end
          end
        end
      end

      COMPARE: begin
        ra_d    = score_a;
        rb_d    = score_b;
        att_d   = (att_q == ATT_MAX) ? ATT_MAX : att_q + 4'd1;
        match_d = 1'b1;
        show_d  = 1'b1;
        blink_d = '0;
        tog_d   = '0;
        state_d = RESULT;
      end

      RESULT: begin
        if (blink_q == BLINK_LAST) begin
          blink_d = '0;
          if (tog_q == TOG_LAST) begin
            // Final toggle blanks the display and ends the round step.
            show_d  = 1'b0;
            match_d = 1'b0;
            tog_d   = '0;
            cnt_d   = '0;
            state_d = (ra_q == SCORE_W'(NUM_DIGITS)) ? Q_ENTRY : A_ENTRY;
          end else begin
            show_d = ~show_q;
            tog_d  = tog_q + TOG_W'(1);
          end
        end else begin
          blink_d = blink_q + BLINK_W'(1);
        end
      end

      default: state_d = Q_ENTRY;
    endcase
  end

  assign bus.qa_state    = (state_q != Q_ENTRY);
  assign bus.digit_state = (cnt_q == CNT_FULL) ? 2'd3 : cnt_q[1:0];
  assign bus.match       = match_q;
  assign bus.show        = show_q;
  assign bus.r_a         = ra_q;
  assign bus.r_b         = rb_q;
  assign bus.attempts    = att_q;

endmodule
`default_nettype wire

// File: tb/tb_guess_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_guess_game_ctrl
// Description : Self-checking bench for guess_game_ctrl. A timeline model of
//               the game (entry phases, a busy window after each scored
//               guess, counting-based A/B scoring) predicts every output each
//               cycle; directed scenarios add literal expectations.
// Ports       : none
// Revision    : 1.0  initial release
// ============================================================================
module tb_guess_game_ctrl;
  import guess_pkg::*;

  localparam int BC  = 2;
  localparam int BT  = 4;
  localparam int WIN = BC * BT;   // result display length in cycles

  logic clk_div = 1'b0;
  logic reset   = 1'b1;

  always #5 clk_div = ~clk_div;

  guess_game_ctrl_if bus ();

  guess_game_ctrl #(
    .BLINK_CYCLES  (BC),
    .BLINK_TOGGLES (BT)
  ) dut (
    .clk_div (clk_div),
    .reset   (reset),
    .bus     (bus)
  );

  // ---------------- behavioural model ----------------
  int m_qa, m_cnt, m_ra, m_rb, m_att, m_match, m_show;
  int m_busy;          // cycles left in which keys are ignored
  int p_a, p_b;        // score of the guess being processed
  int m_q [4];
  int m_g [4];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void score(input int q [4], input int g [4],
                                output int a, output int b);
    int cq [10];
    int cg [10];
    int tot;
    a   = 0;
    tot = 0;
    for (int d = 0; d < 10; d++) begin cq[d] = 0; cg[d] = 0; end
    for (int i = 0; i < 4; i++) begin
      if (q[i] == g[i]) a++;
      cq[q[i]]++;
      cg[g[i]]++;
    end
    for (int d = 0; d < 10; d++) tot += (cq[d] < cg[d]) ? cq[d] : cg[d];
    b = tot - a;
  endfunction

  task automatic model_reset();
    m_qa = 0; m_cnt = 0; m_ra = 0; m_rb = 0; m_att = 0;
    m_match = 0; m_show = 0; m_busy = 0; p_a = 0; p_b = 0;
    for (int i = 0; i < 4; i++) begin m_q[i] = 0; m_g[i] = 0; end
  endtask

  // Advance the model across one clock edge with the given key input.
  task automatic model_step(input bit kv, input int kc);
    int idx;
    if (m_busy > 0) begin
      if (m_busy == 1 + WIN) begin
        m_ra  = p_a;
        m_rb  = p_b;
        m_att = (m_att < 15) ? m_att + 1 : 15;
      end
      m_busy--;
      if (m_busy > 0) begin
        idx     = WIN - m_busy;
        m_match = 1;
        m_show  = ((idx / BC) % 2 == 0) ? 1 : 0;
      end else begin
        m_match = 0;
        m_show  = 0;
        m_cnt   = 0;
        m_qa    = (m_ra != 4) ? 1 : 0;
      end
    end else if (kv) begin
      if (kc <= 9) begin
        if (m_cnt < 4) begin
          if (m_qa == 0) m_q[m_cnt] = kc;
          else           m_g[m_cnt] = kc;
          m_cnt++;
        end
      end else if (kc == 10) begin
        m_cnt = 0;
      end else if (kc == 11 && m_cnt == 4) begin
        if (m_qa == 0) begin
          m_qa = 1; m_cnt = 0; m_att = 0;
        end else begin
          score(m_q, m_g, p_a, p_b);
          m_busy = 1 + WIN;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("qa_state",    int'(bus.qa_state),    m_qa);
    check("digit_state", int'(bus.digit_state), (m_cnt == 4) ? 3 : m_cnt);
    check("match",       int'(bus.match),       m_match);
    check("show",        int'(bus.show),        m_show);
    check("r_a",         int'(bus.r_a),         m_ra);
    check("r_b",         int'(bus.r_b),         m_rb);
    check("attempts",    int'(bus.attempts),    m_att);
  endtask

  // Called at a negedge: apply input, cross the posedge, compare at negedge.
  task automatic cycle(input bit kv, input int kc);
    bus.key_valid = kv;
    bus.key_code  = 4'(kc);
    @(posedge clk_div);
    model_step(kv, kc);
    @(negedge clk_div);
    compare_all();
  endtask

  task automatic press(input int kc);
    cycle(1'b1, kc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0);
  endtask

  task automatic enter4(input int d0, input int d1, input int d2, input int d3);
    press(d0); press(d1); press(d2); press(d3); press(11);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk_div);
    reset = 1'b1;
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    model_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk_div);
    compare_all();
    check("reset_match", int'(bus.match), 0);
    reset = 1'b1;

    // Round 1: 1234 vs 1243 -> 2A2B
    enter4(1, 2, 3, 4);
    enter4(1, 2, 4, 3);
    check("r1_match_early", int'(bus.match), 0);
    idle(1);
    check("r1_ra", int'(bus.r_a), 2);
    check("r1_rb", int'(bus.r_b), 2);
    check("r1_match", int'(bus.match), 1);
    check("r1_show", int'(bus.show), 1);
    idle(BC);
    check("r1_show_toggled", int'(bus.show), 0);
    idle(WIN - BC);
    check("r1_match_end", int'(bus.match), 0);
    check("r1_qa", int'(bus.qa_state), 1);
    check("r1_ds", int'(bus.digit_state), 0);
    check("r1_att", int'(bus.attempts), 1);

    // Round 2: exact hit returns to question entry
    reset = 1'b1;
    do_reset();
    enter4(5, 6, 7, 8);
    enter4(5, 6, 7, 8);
    idle(1);
    check("r2_ra", int'(bus.r_a), 4);
    check("r2_rb", int'(bus.r_b), 0);
    idle(WIN);
    check("r2_qa", int'(bus.qa_state), 0);
    check("r2_ds", int'(bus.digit_state), 0);
    check("r2_att_held", int'(bus.attempts), 1);

    // Round 3: duplicates, 1122 vs 2113 -> 1A2B; attempts cleared on question enter
    enter4(1, 1, 2, 2);
    check("r3_att_clr", int'(bus.attempts), 0);
    enter4(2, 1, 1, 3);
    idle(1);
    check("r3_ra", int'(bus.r_a), 1);
    check("r3_rb", int'(bus.r_b), 2);
    // Digit keys during RESULT must not leak into the next guess
    press(7); press(7); press(11);
    idle(WIN - 3);
    check("r3_ds_after", int'(bus.digit_state), 0);

    // Key handling during guess entry
    press(4); press(4); press(4); press(11);
    check("k_enter3_ds", int'(bus.digit_state), 3);
    check("k_enter3_match", int'(bus.match), 0);
    press(4);
    press(9);
    check("k_5th_ds", int'(bus.digit_state), 3);
    press(10);
    check("k_clear_ds", int'(bus.digit_state), 0);
    press(12); press(13); press(14); press(15);
    check("k_cf_ds", int'(bus.digit_state), 0);
    enter4(2, 1, 1, 3);
    idle(1);
    check("k_ra", int'(bus.r_a), 1);
    check("k_rb", int'(bus.r_b), 2);

    // Reset in the middle of the result display
    idle(3);
    check("mid_match", int'(bus.match), 1);
    do_reset();
    check("rst_match", int'(bus.match), 0);
    check("rst_ra", int'(bus.r_a), 0);

    // Attempts saturation
    enter4(1, 2, 3, 4);
    for (int n = 0; n < 16; n++) begin
      enter4(5, 5, 5, 5);
      idle(1 + WIN);
    end
    check("att_sat", int'(bus.attempts), 15);

    // Randomized play
    for (int c = 0; c < 4000; c++) begin
      int r;
      int kc;
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        r = int'($urandom_range(0, 19));
        if (r < 12)      kc = int'($urandom_range(0, 3));
        else if (r < 16) kc = 11;
        else if (r < 17) kc = 10;
        else             kc = int'($urandom_range(12, 15));
        cycle(1'($urandom_range(0, 1)), kc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
